grf_wb_arbiter: RTL and testbench

Shares the single write port of the 32×32 general register file between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). The block holds one MDU result in a buffer when the port is busy, and forces a pipeline hold if that result waits too long. It also keeps a per-register scoreboard of outstanding MDU destinations, which the hazard unit uses to stall readers. It sits between the W stage, the MDU and the register file's `WE/Waddr/WD/WPC` inputs.

---
 rtl/grf_wb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_grf_wb_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter.sv
// Register-file write-port arbiter between the W stage and the MDU.
// It holds one MDU result in a buffer and keeps a scoreboard of outstanding MDU destinations.
module grf_wb_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_wd,
    input  logic [31:0] pipe_pc,
    output logic        pipe_hold,

    input  logic        mdu_valid,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_wd,
    input  logic [31:0] mdu_pc,
    output logic        mdu_ready,

    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_addr,

    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        rs_busy,
    output logic        rt_busy,

    output logic        grf_we,
    output logic [4:0]  grf_waddr,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_wpc
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] WAIT_MAX  = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } state_t;

    state_t        state_reg;
    logic          buf_full_reg;
    logic [4:0]    buf_addr_reg;
    logic [31:0]   buf_wd_reg;
    logic [31:0]   buf_pc_reg;
    logic [CW-1:0] wait_reg;
    logic          sb_reg [32];

    logic        forcing;
    logic        pipe_req;
    logic        accept;
    logic        mdu_nz;
    logic        grant_pipe;
    logic        grant_buf;
    logic        grant_mdu;
    logic        buffer_now;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    assign forcing  = (state_reg == FORCE);
    assign pipe_req = pipe_we && (pipe_addr != 5'd0);
    assign mdu_nz   = (mdu_addr != 5'd0);

    // Outputs are gated by reset_n so they drop immediately on an asynchronous reset.
    assign mdu_ready = reset_n && !buf_full_reg && !forcing;
    assign accept    = mdu_valid && mdu_ready;
    assign pipe_hold = reset_n && forcing;

    assign grant_buf  = reset_n && (forcing || (buf_full_reg && !pipe_req));
    assign grant_pipe = reset_n && !forcing && pipe_req;
    assign grant_mdu  = accept && mdu_nz && !pipe_req;
    assign buffer_now = accept && mdu_nz && pipe_req;

    always_comb begin
        grf_we    = 1'b0;
        grf_waddr = 5'd0;
        grf_wd    = 32'd0;
        grf_wpc   = 32'd0;
        if (grant_buf) begin
            grf_we    = 1'b1;
            grf_waddr = buf_addr_reg;
            grf_wd    = buf_wd_reg;
            grf_wpc   = buf_pc_reg;
        end else if (grant_pipe) begin
            grf_we    = 1'b1;
            grf_waddr = pipe_addr;
            grf_wd    = pipe_wd;
            grf_wpc   = pipe_pc;
        end else if (grant_mdu) begin
            grf_we    = 1'b1;
            grf_waddr = mdu_addr;
            grf_wd    = mdu_wd;
            grf_wpc   = mdu_pc;
        end
    end

    // Buffer, wait counter and state move together; an IDLE buffer is always empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            buf_full_reg <= 1'b0;
            buf_addr_reg <= 5'd0;
            buf_wd_reg   <= 32'd0;
            buf_pc_reg   <= 32'd0;
            wait_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (buffer_now) begin
                        state_reg    <= HELD;
                        buf_full_reg <= 1'b1;
                        buf_addr_reg <= mdu_addr;
                        buf_wd_reg   <= mdu_wd;
                        buf_pc_reg   <= mdu_pc;
                        wait_reg     <= '0;
                    end
                end
                HELD: begin
                    if (grant_buf) begin
                        state_reg    <= IDLE;
                        buf_full_reg <= 1'b0;
                        wait_reg     <= '0;
                    end else if (wait_reg >= WAIT_LAST) begin
                        // This loss is the MAX_WAIT-th: force the buffer out next cycle.
                        state_reg <= FORCE;
                        wait_reg  <= WAIT_MAX;
                    end else begin
                        wait_reg <= wait_reg + 1'b1;
                    end
                end
                FORCE: begin
                    state_reg    <= IDLE;
                    buf_full_reg <= 1'b0;
                    wait_reg     <= '0;
                end
                default: begin
                    state_reg    <= IDLE;
                    buf_full_reg <= 1'b0;
                    wait_reg     <= '0;
                end
            endcase
        end
    end

    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (mdu_issue && (mdu_issue_addr != 5'd0)) begin
            set_mask[mdu_issue_addr] = 1'b1;
        end
        if (grant_buf) begin
            clr_mask[buf_addr_reg] = 1'b1;
        end else if (grant_mdu) begin
            clr_mask[mdu_addr] = 1'b1;
        end
    end

    // A set outranks a clear on the same bit; bit 0 can never be set.
    for (genvar gi = 0; gi < 32; gi++) begin : g_sb
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sb_reg[gi] <= 1'b0;
            end else if (set_mask[gi]) begin
                sb_reg[gi] <= 1'b1;
            end else if (clr_mask[gi]) begin
                sb_reg[gi] <= 1'b0;
            end
        end
    end

    assign rs_busy = reset_n && sb_reg[rs_addr];
    assign rt_busy = reset_n && sb_reg[rt_addr];

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of the write-port rules.
module tb_grf_wb_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_addr = 5'd0;
    logic [31:0] pipe_wd = 32'd0;
    logic [31:0] pipe_pc = 32'd0;
    logic        pipe_hold;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_addr = 5'd0;
    logic [31:0] mdu_wd = 32'd0;
    logic [31:0] mdu_pc = 32'd0;
    logic        mdu_ready;
    logic        mdu_issue = 1'b0;
    logic [4:0]  mdu_issue_addr = 5'd0;
    logic [4:0]  rs_addr = 5'd0;
    logic [4:0]  rt_addr = 5'd0;
    logic        rs_busy;
    logic        rt_busy;
    logic        grf_we;
    logic [4:0]  grf_waddr;
    logic [31:0] grf_wd;
    logic [31:0] grf_wpc;

    grf_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
        .pipe_hold(pipe_hold),
        .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_wd(mdu_wd), .mdu_pc(mdu_pc),
        .mdu_ready(mdu_ready),
        .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .grf_we(grf_we), .grf_waddr(grf_waddr), .grf_wd(grf_wd), .grf_wpc(grf_wpc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: at most one waiting MDU result, with the number of cycles it has lost so far.
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wd;
        logic [31:0] pc;
        int          lost;
    } res_t;

    res_t        held_q[$];
    bit   [31:0] busy_m = 32'd0;
    bit          m_forced, m_ready, m_pipe, m_acc;
    int          m_win;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_wd, e_pc;
    res_t        m_new;

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_grf_we", grf_we, 0);
            check("rst_mdu_ready", mdu_ready, 0);
            check("rst_pipe_hold", pipe_hold, 0);
            check("rst_waddr", grf_waddr, 0);
            check("rst_wd", grf_wd, 0);
            check("rst_wpc", grf_wpc, 0);
            check("rst_rs_busy", rs_busy, 0);
            check("rst_rt_busy", rt_busy, 0);
            held_q.delete();
            busy_m = 32'd0;
        end else begin
            m_forced = (held_q.size() != 0) && (held_q[0].lost >= MAX_WAIT);
            m_ready  = (held_q.size() == 0);
            m_pipe   = pipe_we && (pipe_addr != 5'd0);
            m_acc    = mdu_valid && m_ready;
            if (m_forced)                         m_win = 2;
            else if (m_pipe)                      m_win = 1;
            else if (held_q.size() != 0)          m_win = 2;
            else if (m_acc && mdu_addr != 5'd0)   m_win = 3;
            else                                  m_win = 0;
            e_we = 1'b0; e_addr = 5'd0; e_wd = 32'd0; e_pc = 32'd0;
            case (m_win)
                1: begin e_we = 1'b1; e_addr = pipe_addr;     e_wd = pipe_wd;     e_pc = pipe_pc;     end
                2: begin e_we = 1'b1; e_addr = held_q[0].addr; e_wd = held_q[0].wd; e_pc = held_q[0].pc; end
                3: begin e_we = 1'b1; e_addr = mdu_addr;      e_wd = mdu_wd;      e_pc = mdu_pc;      end
                default: ;
            endcase
            check("grf_we", grf_we, e_we);
            check("grf_waddr", grf_waddr, e_addr);
            check("grf_wd", grf_wd, e_wd);
            check("grf_wpc", grf_wpc, e_pc);
            check("mdu_ready", mdu_ready, m_ready);
            check("pipe_hold", pipe_hold, m_forced);
            check("rs_busy", rs_busy, busy_m[rs_addr]);
            check("rt_busy", rt_busy, busy_m[rt_addr]);
            // Next-cycle effects: clears first, then issue sets override them.
            if (m_win == 2) begin
                busy_m[held_q[0].addr] = 1'b0;
                void'(held_q.pop_front());
            end else if (held_q.size() != 0) begin
                held_q[0].lost++;
            end
            if (m_win == 3) busy_m[mdu_addr] = 1'b0;
            if (m_acc && mdu_addr != 5'd0 && m_win == 1) begin
                m_new.addr = mdu_addr; m_new.wd = mdu_wd; m_new.pc = mdu_pc; m_new.lost = 0;
                held_q.push_back(m_new);
            end
            if (mdu_issue && mdu_issue_addr != 5'd0) busy_m[mdu_issue_addr] = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    bit acc_seen, hold_seen, burst;

    initial begin
        // Reset while the pipe requests a write
        pipe_we = 1'b1; pipe_addr = 5'd5; pipe_wd = 32'h11; pipe_pc = 32'h100;
        @(negedge clk);
        check("t1_rst_we", grf_we, 0);
        check("t1_rst_ready", mdu_ready, 0);
        tick(); tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("t1_we", grf_we, 1);
        check("t1_waddr", grf_waddr, 5);
        check("t1_wd", grf_wd, 32'h11);

        // MDU only, destination previously issued
        tick();
        pipe_we = 1'b0; mdu_issue = 1'b1; mdu_issue_addr = 5'd8; rs_addr = 5'd8;
        tick();
        mdu_issue = 1'b0;
        @(negedge clk);
        check("t2_busy_set", rs_busy, 1);
        tick();
        mdu_valid = 1'b1; mdu_addr = 5'd8; mdu_wd = 32'hABCD; mdu_pc = 32'h400;
        @(negedge clk);
        check("t2_we", grf_we, 1);
        check("t2_waddr", grf_waddr, 8);
        check("t2_wd", grf_wd, 32'hABCD);
        check("t2_wpc", grf_wpc, 32'h400);
        check("t2_ready", mdu_ready, 1);
        tick();
        mdu_valid = 1'b0;
        @(negedge clk);
        check("t2_busy_clr", rs_busy, 0);
        check("t2_idle_we", grf_we, 0);

        // Collision: pipe $3 and MDU $4, then one more pipe write before the port frees
        tick();
        pipe_we = 1'b1; pipe_addr = 5'd3; pipe_wd = 32'h33;
        mdu_valid = 1'b1; mdu_addr = 5'd4; mdu_wd = 32'h44; mdu_pc = 32'h404;
        @(negedge clk);
        check("t3_pipe_waddr", grf_waddr, 3);
        check("t3_pipe_wd", grf_wd, 32'h33);
        tick();
        mdu_valid = 1'b0; pipe_addr = 5'd6; pipe_wd = 32'h66;
        @(negedge clk);
        check("t3_ready_low", mdu_ready, 0);
        check("t3_pipe2_waddr", grf_waddr, 6);
        tick();
        pipe_we = 1'b0;
        @(negedge clk);
        check("t3_buf_waddr", grf_waddr, 4);
        check("t3_buf_wd", grf_wd, 32'h44);
        check("t3_ready_still_low", mdu_ready, 0);
        tick();
        @(negedge clk);
        check("t3_ready_back", mdu_ready, 1);

        // Starvation: buffered $12 loses MAX_WAIT times, then FORCE
        tick();
        pipe_we = 1'b1; pipe_addr = 5'd10; pipe_wd = 32'hA0;
        mdu_valid = 1'b1; mdu_addr = 5'd12; mdu_wd = 32'hC0DE; mdu_pc = 32'h408;
        @(negedge clk);
        check("t4_first_waddr", grf_waddr, 10);
        for (int i = 0; i < MAX_WAIT; i++) begin
            tick();
            mdu_valid = 1'b0; pipe_addr = 5'(16 + i); pipe_wd = 32'(16 + i);
            @(negedge clk);
            check("t4_lost_waddr", grf_waddr, 16 + i);
            check("t4_lost_hold", pipe_hold, 0);
        end
        tick();
        pipe_addr = 5'd20; pipe_wd = 32'h20;
        @(negedge clk);
        check("t4_force_hold", pipe_hold, 1);
        check("t4_force_waddr", grf_waddr, 12);
        check("t4_force_wd", grf_wd, 32'hC0DE);
        tick();
        @(negedge clk);
        check("t4_after_hold", pipe_hold, 0);
        check("t4_after_waddr", grf_waddr, 20);
        check("t4_after_ready", mdu_ready, 1);

        // Addr-0 and set-beats-clear on the scoreboard
        tick();
        pipe_we = 1'b0; mdu_issue = 1'b1; mdu_issue_addr = 5'd0; rs_addr = 5'd0;
        tick();
        mdu_issue = 1'b0;
        @(negedge clk);
        check("t5_zero_busy", rs_busy, 0);
        tick();
        mdu_issue = 1'b1; mdu_issue_addr = 5'd9; rt_addr = 5'd9;
        mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_wd = 32'h99; mdu_pc = 32'h40C;
        @(negedge clk);
        check("t5_direct_waddr", grf_waddr, 9);
        tick();
        mdu_issue = 1'b0; mdu_valid = 1'b0;
        @(negedge clk);
        check("t5_set_wins", rt_busy, 1);

        // Reset mid-operation discards the buffered result
        tick();
        pipe_we = 1'b1; pipe_addr = 5'd1; pipe_wd = 32'h1;
        mdu_valid = 1'b1; mdu_addr = 5'd2; mdu_wd = 32'hDEAD; mdu_pc = 32'h410;
        tick();
        reset_n = 1'b0; pipe_we = 1'b0; mdu_valid = 1'b0;
        #1;
        check("t6_async_we", grf_we, 0);
        check("t6_async_ready", mdu_ready, 0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        check("t6_discarded_we", grf_we, 0);
        check("t6_ready", mdu_ready, 1);

        // Random traffic; MDU holds its result until accepted, pipe holds while pipe_hold
        burst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc_seen  = mdu_valid && mdu_ready;
            hold_seen = pipe_hold;
            tick();
            if (c % 40 == 0) burst = ($urandom_range(0, 1) == 1);
            if (!reset_n) reset_n = 1'b1;
            else if (c % 800 == 799) reset_n = 1'b0;
            if (!hold_seen) begin
                pipe_we   = ($urandom_range(0, 99) < (burst ? 92 : 40));
                pipe_addr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                pipe_wd   = $urandom;
                pipe_pc   = $urandom;
            end
            if (!mdu_valid || acc_seen) begin
                mdu_valid = ($urandom_range(0, 99) < 35);
                mdu_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                mdu_wd    = $urandom;
                mdu_pc    = $urandom;
            end
            mdu_issue      = ($urandom_range(0, 99) < 25);
            mdu_issue_addr = 5'($urandom_range(0, 31));
            rs_addr        = 5'($urandom_range(0, 31));
            rt_addr        = 5'($urandom_range(0, 31));
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
